lsu: RTL



---
 rtl/lsu_pkg.sv | 38 +++
 rtl/lsu_if.sv | 22 ++
 rtl/lsu_align.sv | 80 ++++++++
 rtl/lsu.sv | 139 +++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: bus widths, memory op codes,
// FSM state encodings and small op-classification helpers.
package lsu_pkg;

  localparam int              REG_BUS      = 32;
  localparam int              REG_ADDR_BUS = 5;
  localparam logic            RESETABLE    = 1'b0;
  localparam logic [4:0]      NOP_REG_ADDR = 5'b00000;
  localparam logic [31:0]     ZERO_WORD    = 32'h0000_0000;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_BUSY = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_e;

  function automatic logic is_load(input mem_op_e op);
    return (op == MEM_LB) || (op == MEM_LBU) || (op == MEM_LH) ||
           (op == MEM_LHU) || (op == MEM_LW);
  endfunction

  function automatic logic is_store(input mem_op_e op);
    return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
interface lsu_if;
  import lsu_pkg::*;

  logic               dm_req;
  logic               dm_we;
  logic [REG_BUS-1:0] dm_addr;
  logic [3:0]         dm_be;
  logic [REG_BUS-1:0] dm_wdata;
  logic               dm_ack;
  logic [REG_BUS-1:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: big-endian byte enables, store replication,
// misalignment flags and load extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  mem_op_e            op,
  input  logic [1:0]         addr_lo,
  input  logic [REG_BUS-1:0] store_data,
  input  logic [REG_BUS-1:0] rdata,
  output logic [3:0]         be,
  output logic [REG_BUS-1:0] store_wdata,
  output logic               adel,
  output logic               ades,
  output logic [REG_BUS-1:0] load_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Byte enables, replicated store data and misalignment per op size
  always_comb begin
    be          = 4'b0000;
    store_wdata = ZERO_WORD;
    adel        = 1'b0;
    ades        = 1'b0;
    case (op)
      MEM_LB, MEM_LBU: be = 4'b1000 >> addr_lo;
      MEM_SB: begin
        be          = 4'b1000 >> addr_lo;
        store_wdata = {4{store_data[7:0]}};
      end
      MEM_LH, MEM_LHU: begin
        be   = 4'b1100 >> addr_lo;
        adel = addr_lo[0];
      end
      MEM_SH: begin
        be          = 4'b1100 >> addr_lo;
        store_wdata = {2{store_data[15:0]}};
        ades        = addr_lo[0];
      end
      MEM_LW: begin
        be   = 4'b1111;
        adel = |addr_lo;
      end
      MEM_SW: begin
        be          = 4'b1111;
        store_wdata = store_data;
        ades        = |addr_lo;
      end
      default: be = 4'b0000;
    endcase
  end

  // Offset 0 is the most significant byte of the word
  always_comb begin
    byte_s = rdata[31:24];
    case (addr_lo)
      2'd0:    byte_s = rdata[31:24];
      2'd1:    byte_s = rdata[23:16];
      2'd2:    byte_s = rdata[15:8];
      2'd3:    byte_s = rdata[7:0];
      default: byte_s = rdata[31:24];
    endcase
    half_s = addr_lo[1] ? rdata[15:0] : rdata[31:16];
  end

  // Extend the selected lane to a full register word
  always_comb begin
    load_data = ZERO_WORD;
    case (op)
      MEM_LB:  load_data = {{24{byte_s[7]}}, byte_s};
      MEM_LBU: load_data = {24'h000000, byte_s};
      MEM_LH:  load_data = {{16{half_s[15]}}, half_s};
      MEM_LHU: load_data = {16'h0000, half_s};
      MEM_LW:  load_data = rdata;
      default: load_data = ZERO_WORD;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: launches one bus transaction per memory op, stalls the
// pipeline until ack, and hands the aligned result to the mem stage.
module lsu
  import lsu_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [3:0]              op_i,
  input  logic [REG_BUS-1:0]      mem_addr_i,
  input  logic [REG_BUS-1:0]      store_data_i,
  input  logic [REG_ADDR_BUS-1:0] wd_i,
  input  logic                    wreg_i,
  input  logic [REG_BUS-1:0]      wdata_i,
  output logic [REG_ADDR_BUS-1:0] wd_o,
  output logic                    wreg_o,
  output logic [REG_BUS-1:0]      wdata_o,
  output logic                    stallreq_o,
  lsu_if.master                   dm,
  output logic                    adel_o,
  output logic                    ades_o
);

  mem_op_e            op_s;
  lsu_state_e         state_r, next_state_s;
  logic               in_reset_s, is_mem_s, launch_s;
  logic               dm_req_r, dm_we_r;
  logic [REG_BUS-1:0] dm_addr_r, dm_wdata_r, rdata_r;
  logic [3:0]         dm_be_r;
  logic [3:0]         be_s;
  logic [REG_BUS-1:0] store_wdata_s, load_data_s;
  logic               adel_s, ades_s;

  assign op_s       = mem_op_e'(op_i);
  assign in_reset_s = (rst == RESETABLE);
  assign is_mem_s   = is_load(op_s) || is_store(op_s);
  assign launch_s   = (state_r == LSU_IDLE) && is_mem_s && !adel_s && !ades_s;

  lsu_align u_align (
    .op          (op_s),
    .addr_lo     (mem_addr_i[1:0]),
    .store_data  (store_data_i),
    .rdata       (rdata_r),
    .be          (be_s),
    .store_wdata (store_wdata_s),
    .adel        (adel_s),
    .ades        (ades_s),
    .load_data   (load_data_s)
  );

  // State register, bus request registers and read-data capture
  always_ff @(posedge clk) begin
    if (in_reset_s) begin
      state_r    <= LSU_IDLE;
      dm_req_r   <= 1'b0;
      dm_we_r    <= 1'b0;
      dm_addr_r  <= ZERO_WORD;
      dm_be_r    <= 4'b0000;
      dm_wdata_r <= ZERO_WORD;
      rdata_r    <= ZERO_WORD;
    end else begin
      state_r <= next_state_s;
      case (state_r)
        LSU_IDLE: begin
          if (launch_s) begin
            dm_req_r   <= 1'b1;
            dm_we_r    <= is_store(op_s);
            dm_addr_r  <= {mem_addr_i[REG_BUS-1:2], 2'b00};
            dm_be_r    <= be_s;
            dm_wdata_r <= store_wdata_s;
          end
        end
        LSU_BUSY: begin
          if (dm.dm_ack) begin
            dm_req_r <= 1'b0;
            rdata_r  <= dm.dm_rdata;
          end
        end
        default: dm_req_r <= 1'b0;
      endcase
    end
  end

  // Next state plus stall, writeback and exception outputs
  always_comb begin
    next_state_s = state_r;
    wd_o         = NOP_REG_ADDR;
    wreg_o       = 1'b0;
    wdata_o      = ZERO_WORD;
    stallreq_o   = 1'b0;
    adel_o       = 1'b0;
    ades_o       = 1'b0;
    if (in_reset_s) begin
      next_state_s = LSU_IDLE;
    end else begin
      case (state_r)
        LSU_IDLE: begin
          if (is_mem_s) begin
            wd_o = wd_i;
            if (launch_s) begin
              stallreq_o   = 1'b1;
              next_state_s = LSU_BUSY;
            end else begin
              adel_o = adel_s;
              ades_o = ades_s;
            end
          end else begin
            wd_o    = wd_i;
            wreg_o  = wreg_i;
            wdata_o = wdata_i;
          end
        end
        LSU_BUSY: begin
          wd_o         = wd_i;
          stallreq_o   = 1'b1;
          next_state_s = dm.dm_ack ? LSU_DONE : LSU_BUSY;
        end
        LSU_DONE: begin
          // Inputs still hold the finished op here; it must not relaunch
          wd_o         = wd_i;
          next_state_s = LSU_IDLE;
          if (is_load(op_s)) begin
            wreg_o  = wreg_i;
            wdata_o = load_data_s;
          end else begin
            wreg_o  = 1'b0;
          end
        end
        default: next_state_s = LSU_IDLE;
      endcase
    end
  end

  assign dm.dm_req   = in_reset_s ? 1'b0      : dm_req_r;
  assign dm.dm_we    = in_reset_s ? 1'b0      : dm_we_r;
  assign dm.dm_addr  = in_reset_s ? ZERO_WORD : dm_addr_r;
  assign dm.dm_be    = in_reset_s ? 4'b0000   : dm_be_r;
  assign dm.dm_wdata = in_reset_s ? ZERO_WORD : dm_wdata_r;

endmodule
